// File: rtl/io_bus_scheduler.sv
// io_bus_scheduler: sequences the shared 8-bit I/O-board bus between
// a background image scanner and a single-byte CPU access port.
module io_bus_scheduler #(
    parameter int BOARDS           = 16,
    parameter int INSTALLED_BOARDS = 2,
    parameter int SETUP_CYCLES     = 1,
    parameter int STROBE_CYCLES    = 2,
    parameter int HOLD_CYCLES      = 1
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  scan_en,
    input  logic [8*BOARDS-1:0]   outputs,
    output logic [8*BOARDS-1:0]   inputs,
    output logic                  scan_done,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [3:0]            cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic                  cpu_ack,
    output logic [7:0]            cpu_rdata,
    output logic [3:0]            io_address,
    output logic [1:0]            io_enable_n,
    output logic [7:0]            io_data_out,
    output logic                  io_data_oe,
    input  logic [7:0]            io_data_in
);

    localparam int CW = 8;
    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [3:0]    LAST_BOARD  = 4'(INSTALLED_BOARDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    typedef enum logic {
        PH_WRITE,
        PH_READ
    } phase_t;

    state_t          state;
    phase_t          phase;
    logic [3:0]      ptr;
    logic [CW-1:0]   cnt;
    logic            we;
    logic            own_cpu;
    logic            last_cpu;
    logic [7:0]      rd_byte;

    logic            cpu_grant;
    logic            cpu_addr_ok;

    // CPU wins IDLE unless it owned the last transaction while scan is waiting
    always_comb begin
        cpu_grant   = cpu_req && !cpu_ack && !(last_cpu && scan_en);
        cpu_addr_ok = (cpu_addr <= LAST_BOARD);
    end

    // Bus sequencer: arbitration, strobe timing, image capture and handshakes
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            phase       <= PH_WRITE;
            ptr         <= '0;
            cnt         <= '0;
            we          <= 1'b0;
            own_cpu     <= 1'b0;
            last_cpu    <= 1'b0;
            rd_byte     <= '0;
            inputs      <= '0;
            scan_done   <= 1'b0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= '0;
            io_address  <= '0;
            io_enable_n <= 2'b11;
            io_data_out <= '0;
            io_data_oe  <= 1'b0;
        end else begin
            cpu_ack   <= 1'b0;
            scan_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_grant) begin
                        last_cpu <= 1'b1;
                        if (cpu_addr_ok) begin
                            own_cpu     <= 1'b1;
                            we          <= cpu_we;
                            cnt         <= '0;
                            state       <= SETUP;
                            io_address  <= cpu_addr;
                            io_data_out <= cpu_wdata;
                            io_data_oe  <= cpu_we;
                        end else begin
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= 8'hFF;
                        end
                    end else if (scan_en) begin
                        last_cpu    <= 1'b0;
                        own_cpu     <= 1'b0;
                        we          <= (phase == PH_WRITE);
                        cnt         <= '0;
                        state       <= SETUP;
                        io_address  <= ptr;
                        io_data_out <= outputs[8*ptr +: 8];
                        io_data_oe  <= (phase == PH_WRITE);
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt         <= '0;
                        state       <= STROBE;
                        io_enable_n <= we ? 2'b10 : 2'b01;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt == STROBE_LAST) begin
                        cnt         <= '0;
                        state       <= HOLD;
                        io_enable_n <= 2'b11;
                        if (!we) begin
                            inputs[8*io_address +: 8] <= io_data_in;
                            rd_byte                   <= io_data_in;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt        <= '0;
                        state      <= IDLE;
                        io_data_oe <= 1'b0;
                        if (own_cpu) begin
                            cpu_ack <= 1'b1;
                            if (!we) begin
                                cpu_rdata <= rd_byte;
                            end
                        end else if (phase == PH_WRITE) begin
                            phase <= PH_READ;
                        end else begin
                            phase <= PH_WRITE;
                            if (ptr == LAST_BOARD) begin
                                ptr       <= '0;
                                scan_done <= 1'b1;
                            end else begin
                                ptr <= ptr + 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_scheduler.sv
// tb_io_bus_scheduler: directed checks of scan order, CPU arbitration,
// uninstalled access, scan pause/resume and mid-strobe reset.
module tb_io_bus_scheduler;

    logic         Clk;
    logic         Rst_n;
    logic         scan_en;
    logic [127:0] outputs;
    logic [127:0] inputs;
    logic         scan_done;
    logic         cpu_req;
    logic         cpu_we;
    logic [3:0]   cpu_addr;
    logic [7:0]   cpu_wdata;
    logic         cpu_ack;
    logic [7:0]   cpu_rdata;
    logic [3:0]   io_address;
    logic [1:0]   io_enable_n;
    logic [7:0]   io_data_out;
    logic         io_data_oe;
    logic [7:0]   io_data_in;

    logic [7:0]   board_rd [16];

    int compared;
    int mismatched;

    io_bus_scheduler dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .scan_en     (scan_en),
        .outputs     (outputs),
        .inputs      (inputs),
        .scan_done   (scan_done),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .io_address  (io_address),
        .io_enable_n (io_enable_n),
        .io_data_out (io_data_out),
        .io_data_oe  (io_data_oe),
        .io_data_in  (io_data_in)
    );

    // Board model: the addressed board answers reads with its byte
    assign io_data_in = board_rd[io_address];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic bus(input string tag, input logic [3:0] a,
                       input logic [1:0] en, input logic oe);
        chk({tag, "_addr"}, 128'(io_address), 128'(a));
        chk({tag, "_en"}, 128'(io_enable_n), 128'(en));
        chk({tag, "_oe"}, 128'(io_data_oe), 128'(oe));
    endtask

    // Strobes are never both low; the bus is never driven during a read strobe
    always @(negedge Clk) begin
        if (Rst_n) begin
            chk("both_strobes", 128'(io_enable_n != 2'b00), 128'(1));
            chk("oe_in_read", 128'(io_data_oe && !io_enable_n[1]), 128'(0));
        end
    end

    logic [1:0] en_tab [10];
    logic       oe_tab [10];
    int         done_cnt;

    initial begin
        en_tab = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b11,
                   2'b11, 2'b01, 2'b01, 2'b11, 2'b11};
        oe_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 16; i++) board_rd[i] = 8'h00;
        board_rd[0] = 8'h3C;
        board_rd[1] = 8'h66;
        outputs   = '0;
        outputs[7:0]  = 8'hA5;
        outputs[15:8] = 8'h5A;
        Rst_n     = 1'b0;
        scan_en   = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;

        cyc();
        cyc();
        chk("rst_en", 128'(io_enable_n), 128'(2'b11));
        chk("rst_oe", 128'(io_data_oe), 128'(0));
        chk("rst_addr", 128'(io_address), 128'(0));
        chk("rst_dout", 128'(io_data_out), 128'(0));
        chk("rst_inputs", inputs, 128'(0));
        chk("rst_ack", 128'(cpu_ack), 128'(0));
        chk("rst_rdata", 128'(cpu_rdata), 128'(0));
        chk("rst_done", 128'(scan_done), 128'(0));

        Rst_n   = 1'b1;
        scan_en = 1'b1;

        // First scan round: 0W, 0R, 1W, 1R, five cycles each
        for (int k = 0; k < 20; k++) begin
            cyc();
            bus($sformatf("scan_k%0d", k), (k < 10) ? 4'd0 : 4'd1,
                en_tab[k % 10], oe_tab[k % 10]);
            chk($sformatf("done_k%0d", k), 128'(scan_done),
                128'(k == 19));
            if (k == 1) chk("wdata_b0", 128'(io_data_out), 128'(8'hA5));
            if (k == 11) chk("wdata_b1", 128'(io_data_out), 128'(8'h5A));
            if (k == 8) chk("img_b0", 128'(inputs[7:0]), 128'(8'h3C));
            if (k == 18) chk("img_b1", 128'(inputs[15:8]), 128'(8'h66));
        end

        // Second round: exactly one scan_done, 20 cycles after the first
        done_cnt = 0;
        for (int k = 20; k < 40; k++) begin
            cyc();
            if (scan_done) done_cnt++;
        end
        chk("done_k39", 128'(scan_done), 128'(1));
        chk("done_count", 128'(done_cnt), 128'(1));

        // CPU read of board 1, held across a scan transaction
        board_rd[1] = 8'h77;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 4'd1;
        cyc();
        bus("cpu1_setup", 4'd1, 2'b11, 1'b0);
        cyc();
        bus("cpu1_strobe", 4'd1, 2'b01, 1'b0);
        cyc();
        cyc();
        cyc();
        chk("cpu1_ack", 128'(cpu_ack), 128'(1));
        chk("cpu1_rdata", 128'(cpu_rdata), 128'(8'h77));
        chk("cpu1_img", 128'(inputs[15:8]), 128'(8'h77));
        cyc();
        bus("alt_scan_0w", 4'd0, 2'b11, 1'b1);
        chk("alt_ack_low", 128'(cpu_ack), 128'(0));
        cyc();
        cyc();
        cyc();
        cyc();
        cyc();
        bus("alt_cpu2", 4'd1, 2'b11, 1'b0);
        cyc();
        cyc();
        cyc();
        cyc();
        chk("cpu2_ack", 128'(cpu_ack), 128'(1));
        cpu_req = 1'b0;
        cyc();
        bus("alt_scan_0r", 4'd0, 2'b11, 1'b0);
        cyc();
        bus("alt_scan_0r_st", 4'd0, 2'b01, 1'b0);
        for (int k = 57; k < 70; k++) cyc();
        chk("done_k69", 128'(scan_done), 128'(1));

        // Uninstalled board: immediate ack, no bus cycle
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 4'd9;
        cpu_wdata = 8'h12;
        cyc();
        chk("unin_ack", 128'(cpu_ack), 128'(1));
        chk("unin_rdata", 128'(cpu_rdata), 128'(8'hFF));
        bus("unin_bus", 4'd1, 2'b11, 1'b0);
        chk("unin_img", 128'(inputs[127:16]), 128'(0));
        cpu_req = 1'b0;
        cyc();
        bus("after_unin", 4'd0, 2'b11, 1'b1);
        chk("after_unin_ack", 128'(cpu_ack), 128'(0));

        // Scan disabled mid-write: the write finishes, then the bus idles
        scan_en = 1'b0;
        cyc();
        bus("dis_strobe", 4'd0, 2'b10, 1'b1);
        for (int k = 73; k < 94; k++) begin
            cyc();
            if (k >= 75) begin
                chk($sformatf("idle_en_k%0d", k), 128'(io_enable_n),
                    128'(2'b11));
                chk($sformatf("idle_oe_k%0d", k), 128'(io_data_oe),
                    128'(0));
            end
        end
        scan_en = 1'b1;
        cyc();
        bus("resume_0r", 4'd0, 2'b11, 1'b0);
        cyc();
        bus("resume_0r_st", 4'd0, 2'b01, 1'b0);
        cyc();
        cyc();
        cyc();

        // CPU write to board 1 interrupted by reset during its strobe
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 4'd1;
        cpu_wdata = 8'h12;
        cyc();
        bus("cpuw_setup", 4'd1, 2'b11, 1'b1);
        chk("cpuw_data", 128'(io_data_out), 128'(8'h12));
        cyc();
        bus("cpuw_strobe", 4'd1, 2'b10, 1'b1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_en", 128'(io_enable_n), 128'(2'b11));
        chk("arst_oe", 128'(io_data_oe), 128'(0));
        chk("arst_addr", 128'(io_address), 128'(0));
        chk("arst_ack", 128'(cpu_ack), 128'(0));
        cpu_req = 1'b0;
        scan_en = 1'b0;
        cyc();
        cyc();
        Rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk($sformatf("post_rst_ack%0d", k), 128'(cpu_ack), 128'(0));
        end
        bus("post_rst_idle", 4'd0, 2'b11, 1'b0);
        chk("post_rst_img", inputs, 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
